// File: rtl/cnn_sched_pkg.sv
// Shared types and default timing constants for the CNN layer scheduler and the control unit
// that instantiates it.
package cnn_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StFinish,
    StErr
  } sched_state_e;

  localparam int unsigned SCHED_NUM_LAYERS  = 4;
  localparam int unsigned LAYER_IDX_W       = $clog2(SCHED_NUM_LAYERS);
  localparam int unsigned SCHED_FEED_PERIOD = 4;
  localparam int unsigned SCHED_FEED_COUNT  = 20;
  localparam int unsigned SCHED_TIMEOUT     = 1023;

endpackage

// File: rtl/sched_feed_pacer.sv
// Paces sample strobes to the active layer: one strobe every FEED_PERIOD cycles, at most
// FEED_COUNT per layer.
module sched_feed_pacer
  import cnn_sched_pkg::*;
#(
  parameter int unsigned FEED_PERIOD = SCHED_FEED_PERIOD,
  parameter int unsigned FEED_COUNT  = SCHED_FEED_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic strobe,
  output logic exhausted
);

  localparam int unsigned PerW = $clog2(FEED_PERIOD);
  localparam int unsigned CntW = $clog2(FEED_COUNT + 1);

  logic [PerW-1:0] period_q, period_d;
  logic [CntW-1:0] issued_q, issued_d;
  logic            strobe_q, strobe_d;

  always_comb begin
    period_d = period_q;
    issued_d = issued_q;
    strobe_d = 1'b0;
    if (clear) begin
      period_d = '0;
      issued_d = '0;
    end else if (enable) begin
      period_d = (period_q == PerW'(FEED_PERIOD - 1)) ? '0 : period_q + PerW'(1);
      // Registered strobe lands in the cycle the period counter shows FEED_PERIOD-1.
      if (period_q == PerW'(FEED_PERIOD - 2) && issued_q != CntW'(FEED_COUNT)) begin
        strobe_d = 1'b1;
        issued_d = issued_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      issued_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      period_q <= period_d;
      issued_q <= issued_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe    = strobe_q;
  assign exhausted = (issued_q == CntW'(FEED_COUNT));

endmodule

// File: rtl/cnn_layer_scheduler.sv
// Sequences the conv/ReLU/maxpool layer controllers for one inference, with per-layer timeout
// and a saturating inference cycle count.
module cnn_layer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = SCHED_NUM_LAYERS,
  parameter int unsigned FEED_PERIOD = SCHED_FEED_PERIOD,
  parameter int unsigned FEED_COUNT  = SCHED_FEED_COUNT,
  parameter int unsigned TIMEOUT     = SCHED_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   abort,
  input  logic [NUM_LAYERS-1:0]  layer_done,
  output logic [NUM_LAYERS-1:0]  layer_start,
  output logic [NUM_LAYERS-1:0]  feed_en,
  output logic [LAYER_IDX_W-1:0] cur_layer,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [LAYER_IDX_W-1:0] err_layer,
  output logic [31:0]            total_cycles
);

  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  localparam logic [LAYER_IDX_W-1:0] LastLayer = LAYER_IDX_W'(NUM_LAYERS - 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  sched_state_e           state_q, state_d;
  logic [LAYER_IDX_W-1:0] cur_q, cur_d, err_layer_q, err_layer_d;
  logic                   error_q, error_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_LAYERS-1:0]  start_q, start_d;
  logic [ToW-1:0]         to_q, to_d;
  logic [31:0]            total_q, total_d;
  logic                   feed_strobe, feed_exhausted, feed_clear, feed_enable;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    error_d     = error_q;
    err_layer_d = err_layer_q;
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StErr: begin
          if (run) begin
            state_d     = StStart;
            cur_d       = '0;
            error_d     = 1'b0;
            err_layer_d = '0;
          end
        end
        StStart: state_d = StRun;
        StRun: begin
          // Done is checked first so a done coinciding with the timeout still advances.
          if (layer_done[cur_q]) begin
            if (cur_q == LastLayer) begin
              state_d = StFinish;
            end else begin
              state_d = StStart;
              cur_d   = cur_q + LAYER_IDX_W'(1);
            end
          end else if (to_q == ToLast) begin
            state_d     = StErr;
            error_d     = 1'b1;
            err_layer_d = cur_q;
          end
        end
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    to_d    = to_q;
    total_d = total_q;
    if (state_q == StStart) begin
      to_d = '0;
    end else if (state_q == StRun) begin
      to_d = to_q + ToW'(1);
    end
    // Only entry from IDLE/ERR targets layer 0, so this clears once per inference.
    if (state_d == StStart && (state_q == StIdle || state_q == StErr)) begin
      total_d = '0;
    end else if ((state_q == StStart || state_q == StRun) && total_q != '1) begin
      total_d = total_q + 32'd1;
    end
  end

  always_comb begin
    start_d = (state_d == StStart) ? (NUM_LAYERS'(1) << cur_d) : '0;
    busy_d  = (state_d == StStart) || (state_d == StRun);
    done_d  = (state_d == StFinish);
  end

  assign feed_clear  = (state_q == StStart);
  assign feed_enable = (state_q == StRun) && (state_d == StRun) && !feed_exhausted;

  sched_feed_pacer #(
    .FEED_PERIOD (FEED_PERIOD),
    .FEED_COUNT  (FEED_COUNT)
  ) u_pacer (
    .clk       (clk),
    .rst       (rst),
    .clear     (feed_clear),
    .enable    (feed_enable),
    .strobe    (feed_strobe),
    .exhausted (feed_exhausted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      error_q     <= 1'b0;
      err_layer_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= '0;
      to_q        <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      error_q     <= error_d;
      err_layer_q <= err_layer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      start_q     <= start_d;
      to_q        <= to_d;
      total_q     <= total_d;
    end
  end

  assign layer_start  = start_q;
  assign feed_en      = feed_strobe ? (NUM_LAYERS'(1) << cur_q) : '0;
  assign cur_layer    = cur_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_layer    = err_layer_q;
  assign total_cycles = total_q;

endmodule

// File: doc/cnn_layer_scheduler.md
Name: cnn_layer_scheduler

Overview:
Sequences the four conv/ReLU/maxpool layer controllers of the 1-D CNN ECG accelerator for one inference. It issues a one-cycle start pulse to each layer in order and paces that layer's sample strobes (its maxflagin). It waits for each layer's done, and enforces a per-layer timeout. It reports overall completion, error status and total inference cycle count to the top-level control unit.

Parameters:
NUM_LAYERS, 4, number of layer controllers sequenced in order 0..NUM_LAYERS-1
FEED_PERIOD, 4, cycles between consecutive feed strobes to the active layer (>=2)
FEED_COUNT, 20, number of feed strobes issued per layer
TIMEOUT, 1023, maximum cycles from a layer's start pulse to its done before error

Ports:
clk  input  1  clock
rst  input  1  reset (asynchronous, active-high)
run  input  1  start one inference (sampled in IDLE only)
abort  input  1  synchronous abort, highest priority after rst
layer_done  input  NUM_LAYERS  done pulse from each layer controller
layer_start  output  NUM_LAYERS  one-hot one-cycle start pulse per layer
feed_en  output  NUM_LAYERS  one-hot sample strobe to active layer (drives its maxflagin)
cur_layer  output  clog2(NUM_LAYERS)  index of active layer
busy  output  1  inference in progress
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky timeout flag
err_layer  output  clog2(NUM_LAYERS)  layer that timed out
total_cycles  output  32  cycles from first start pulse to done, saturating

Behaviour:
- Reset: every output is 0; the state is IDLE; all counters are 0. rst is honoured mid-inference with no completion pulse.
- States: IDLE, START, RUN, FINISH, ERR.
- IDLE, run=1 at edge t -> START. error and err_layer are cleared at t. cur_layer=0 and busy=1 from cycle t+1.
- START: layer_start[cur_layer]=1 for exactly one cycle. The timeout and feed counters reset to 0. total_cycles is cleared on layer 0 only. Next state is RUN.
- RUN, period counter: counts 0..FEED_PERIOD-1 and wraps.
- RUN, feed strobes: feed_en[cur_layer]=1 for one cycle when the counter reaches FEED_PERIOD-1, while feeds_issued<FEED_COUNT. The first strobe is FEED_PERIOD cycles after the start pulse.
- RUN, timeout counter: increments each cycle.
- RUN, layer_done[cur_layer]=1 with more layers remaining: increment cur_layer and go to START. The next start pulse occurs in the cycle after done is sampled.
- RUN, layer_done[cur_layer]=1 on the last layer: go to FINISH.
- Early done: done before all FEED_COUNT strobes is accepted; feeding stops immediately.
- Timeout: the counter reaching TIMEOUT without done -> ERR. error=1 and err_layer=cur_layer.
- Simultaneous done and timeout in the same cycle: done wins.
- layer_done bits of non-active layers are ignored in all states. layer_done in IDLE/ERR is ignored.
- FINISH: done=1 for one cycle and total_cycles is frozen. busy falls in the same cycle done is high. Next state is IDLE.
- ERR: busy=0; error and err_layer hold. Only run (restarts from layer 0, clears error) or rst leaves ERR.
- run while busy: ignored, no restart.
- abort in any non-IDLE state -> IDLE next cycle.
  - layer_start, feed_en, busy and done are 0 from that cycle.
  - No done pulse is issued; error is unchanged.
- Outputs: all are registered; no combinational path from inputs to outputs.
- total_cycles: increments every cycle in START/RUN and saturates at 2^32-1.

Decomposition:
- Shared package cnn_sched_pkg holds:
  - the state enum type;
  - LAYER_IDX_W = clog2(NUM_LAYERS);
  - default FEED_PERIOD/FEED_COUNT/TIMEOUT constants, reused by the top-level control unit.
- Sub-module sched_feed_pacer holds the period counter, the feeds_issued counter and the strobe generation.
  - Inputs: clear, enable.
  - Outputs: strobe, exhausted.
- The FSM, timeout and cycle counters stay in cnn_layer_scheduler.

Test Plan:
- Nominal run: run pulse; each layer returns done 100 cycles after its start.
  - layer_start pulses layers 0,1,2,3 in order, each one cycle after the previous done.
  - Per layer there are exactly 20 feed_en pulses spaced 4 cycles apart, the first 4 cycles after start.
  - A single done pulse follows; total_cycles equals the measured span.
- Timeout: layer 2 never asserts done -> error=1 and err_layer=2 after 1023 cycles in RUN; busy=0, done never pulses. A following run clears error and restarts at layer 0.
- Early and foreign done: layer 1 returns done after 10 cycles -> only 2 feed strobes issued and it advances to layer 2. A layer_done[3] pulse during layer 0 is ignored.
- Boundary: done and timeout coincide on layer 0 -> it advances normally with no error. run held high during busy -> no restart.
- Abort and reset: abort mid-layer 1 -> next cycle busy=0 and all strobes 0 with no done. Async rst mid-layer 3 -> every output is 0 immediately and the state is IDLE.
